// File: rtl/rtdf_packet_parser.sv
// rtdf_packet_parser
//   Ethernet frame parser for the real-time data feed. Reads 16-bit words
//   from a show-ahead RX FIFO, validates the frame header (ethertype, magic,
//   payload length), forwards only payload sample words through a
//   valid/ready handshake and drains padding/CRC. Keeps packet, good-packet
//   and missed-sequence debug counters.
//
// Ports
//   clk                single clock
//   reset_n            asynchronous active-low reset
//   rx_fifo_empty      RX FIFO empty flag (head word valid when low)
//   rx_fifo_rd_data    RX FIFO head word
//   rx_fifo_rd_req     pop request (combinational)
//   out_ready          downstream can accept a payload word
//   out_valid          out_data carries a payload word (combinational)
//   out_data           payload word, unmodified
//   pkt_done           one-cycle pulse after the last pop of a frame
//   packet_count       frames started, mod 512
//   good_packet_count  frames passing all header checks, mod 512
//   missed_count       skipped sequence numbers, mod 512
module rtdf_packet_parser #(
  parameter logic [15:0] ETHERTYPE = 16'h88B5,
  parameter logic [15:0] MAGIC     = 16'h4750,
  parameter logic [15:0] MAX_WORDS = 16'd736
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx_fifo_empty,
  input  logic [15:0] rx_fifo_rd_data,
  output logic        rx_fifo_rd_req,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic        pkt_done,
  output logic [8:0]  packet_count,
  output logic [8:0]  good_packet_count,
  output logic [8:0]  missed_count
);

  typedef enum logic [2:0] {
    S_LEN,
    S_MAC,
    S_TYPE,
    S_MAGIC,
    S_SEQ,
    S_COUNT,
    S_DATA,
    S_DRAIN
  } state_t;

  state_t      r_state;
  logic [15:0] r_w;          // frame words following the length word
  logic [10:0] r_cnt;        // pops since the length word
  logic [15:0] r_left;       // payload words still to forward
  logic [15:0] r_seq;
  logic [15:0] r_expected;
  logic        r_seq_seen;
  logic        r_pkt_done;
  logic [8:0]  r_packet_count;
  logic [8:0]  r_good_count;
  logic [8:0]  r_missed_count;

  logic        w_in_data;
  logic        w_out_valid;
  logic        w_rd_req;
  logic        w_pop;
  logic [10:0] w_cnt_next;
  logic        w_frame_end;
  logic [15:0] w_len_sum;
  logic [15:0] w_len_w;
  logic        w_n_bad;
  logic [15:0] w_seq_diff;

  // Request terms are gated by reset_n so nothing is popped while in reset.
  assign w_in_data   = (r_state == S_DATA);
  assign w_out_valid = reset_n & w_in_data & ~rx_fifo_empty;
  assign w_rd_req    = w_in_data ? (w_out_valid & out_ready)
                                 : (reset_n & ~rx_fifo_empty);
  assign w_pop       = w_rd_req & ~rx_fifo_empty;

  assign w_cnt_next  = r_cnt + 11'd1;
  assign w_frame_end = ({5'd0, w_cnt_next} == r_w);

  // W = (L+1)>>1 with the increment wrapping in 16 bits.
  assign w_len_sum   = rx_fifo_rd_data + 16'd1;
  assign w_len_w     = {1'b0, w_len_sum[15:1]};

  // The header (10 words) and CRC (2 words) must fit around N payload words.
  assign w_n_bad     = (rx_fifo_rd_data > MAX_WORDS) ||
                       ({1'b0, r_w} < (17'd12 + {1'b0, rx_fifo_rd_data}));

  assign w_seq_diff  = r_seq - r_expected;

  assign rx_fifo_rd_req    = w_rd_req;
  assign out_valid         = w_out_valid;
  assign out_data          = rx_fifo_rd_data;
  assign pkt_done          = r_pkt_done;
  assign packet_count      = r_packet_count;
  assign good_packet_count = r_good_count;
  assign missed_count      = r_missed_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_LEN;
      r_w            <= '0;
      r_cnt          <= '0;
      r_left         <= '0;
      r_seq          <= '0;
      r_expected     <= '0;
      r_seq_seen     <= 1'b0;
      r_pkt_done     <= 1'b0;
      r_packet_count <= '0;
      r_good_count   <= '0;
      r_missed_count <= '0;
    end else begin
      r_pkt_done <= 1'b0;
      if (w_pop) begin
        if (r_state == S_LEN) begin
          r_w            <= w_len_w;
          r_cnt          <= '0;
          r_packet_count <= r_packet_count + 9'd1;
          if (w_len_w == 16'd0) begin
            // Empty frame: nothing follows the length word.
            r_pkt_done <= 1'b1;
            r_state    <= S_LEN;
          end else if (w_len_w < 16'd12) begin
            r_state <= S_DRAIN;
          end else begin
            r_state <= S_MAC;
          end
        end else begin
          r_cnt <= w_cnt_next;
          case (r_state)
            S_MAC: begin
              if (r_cnt == 11'd5) r_state <= S_TYPE;
            end
            S_TYPE: begin
              r_state <= (rx_fifo_rd_data == ETHERTYPE) ? S_MAGIC : S_DRAIN;
            end
            S_MAGIC: begin
              r_state <= (rx_fifo_rd_data == MAGIC) ? S_SEQ : S_DRAIN;
            end
            S_SEQ: begin
              r_seq   <= rx_fifo_rd_data;
              r_state <= S_COUNT;
            end
            S_COUNT: begin
              r_left <= rx_fifo_rd_data;
              if (w_n_bad) begin
                r_state <= S_DRAIN;
              end else begin
                r_good_count <= r_good_count + 9'd1;
                if (r_seq_seen) begin
                  r_missed_count <= r_missed_count + w_seq_diff[8:0];
                end
                r_seq_seen <= 1'b1;
                r_expected <= r_seq + 16'd1;
                r_state    <= (rx_fifo_rd_data == 16'd0) ? S_DRAIN : S_DATA;
              end
            end
            S_DATA: begin
              r_left <= r_left - 16'd1;
              if (r_left == 16'd1) r_state <= S_DRAIN;
            end
            default: begin
              r_state <= S_DRAIN;
            end
          endcase
          // Last word of the frame, whatever state consumed it.
          if (w_frame_end) begin
            r_pkt_done <= 1'b1;
            r_state    <= S_LEN;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rtdf_packet_parser.sv
module tb_rtdf_packet_parser;

  localparam logic [15:0] ETYPE  = 16'h88B5;
  localparam logic [15:0] GMAGIC = 16'h4750;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rx_fifo_empty;
  logic [15:0] rx_fifo_rd_data;
  logic        rx_fifo_rd_req;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        pkt_done;
  logic [8:0]  packet_count;
  logic [8:0]  good_packet_count;
  logic [8:0]  missed_count;

  logic [15:0] mem [0:4095];
  logic [11:0] rd_idx = '0;
  logic [11:0] wr_idx = '0;
  logic        gap;
  logic        flush;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned ncap     = 0;
  int unsigned ndone    = 0;
  logic [15:0] cap_data [0:1023];
  int unsigned cap_cyc  [0:1023];

  rtdf_packet_parser dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .rx_fifo_empty     (rx_fifo_empty),
    .rx_fifo_rd_data   (rx_fifo_rd_data),
    .rx_fifo_rd_req    (rx_fifo_rd_req),
    .out_ready         (out_ready),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .pkt_done          (pkt_done),
    .packet_count      (packet_count),
    .good_packet_count (good_packet_count),
    .missed_count      (missed_count)
  );

  assign rx_fifo_empty   = (rd_idx == wr_idx) || gap;
  assign rx_fifo_rd_data = mem[rd_idx];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (flush) rd_idx <= wr_idx;
    else if (rx_fifo_rd_req && !rx_fifo_empty) rd_idx <= rd_idx + 12'd1;
    if (out_valid && out_ready) begin
      cap_data[ncap] <= out_data;
      cap_cyc[ncap]  <= cyc;
      ncap           <= ncap + 1;
    end
    if (pkt_done) ndone <= ndone + 1;
  end

  // Length word, then W words: 6 MAC, type, magic, seq, N, payload, filler.
  task automatic push_frame(input logic [15:0] len, input logic [15:0] magic,
                            input logic [15:0] seq, input logic [15:0] n,
                            input logic [15:0] base);
    logic [15:0] w;
    logic [15:0] wd;
    w = (len + 16'd1) >> 1;
    mem[wr_idx] = len;
    wr_idx = wr_idx + 12'd1;
    for (int unsigned i = 0; i < w; i++) begin
      if (i < 6)                 wd = 16'h0200 + 16'(i);
      else if (i == 6)           wd = ETYPE;
      else if (i == 7)           wd = magic;
      else if (i == 8)           wd = seq;
      else if (i == 9)           wd = n;
      else if ((i - 10) < n)     wd = base + 16'(i - 10);
      else                       wd = 16'hCC00 + 16'(i);
      mem[wr_idx] = wd;
      wr_idx = wr_idx + 12'd1;
    end
  endtask

  task automatic run_frame(input bit stress, input string name);
    int unsigned start;
    int unsigned k;
    start = ndone;
    k = 0;
    while (ndone == start && k < 3000) begin
      @(negedge clk);
      k++;
      if (stress) begin
        out_ready = ~out_ready;
        gap = ($urandom_range(0, 3) == 0);
      end
    end
    gap = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if (ndone == start) begin
      n_fail++;
      $display("FAIL %s.timeout pkt_done not seen after %0d cycles", name, k);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    mem[wr_idx] = 16'h0060;
    wr_idx = wr_idx + 12'd1;
    #1;
    n_checks++; if (rx_fifo_rd_req !== 1'b0) begin n_fail++; $display("FAIL reset.rd_req got %b want 0", rx_fifo_rd_req); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset.out_valid got %b want 0", out_valid); end
    n_checks++; if (pkt_done !== 1'b0) begin n_fail++; $display("FAIL reset.pkt_done got %b want 0", pkt_done); end
    n_checks++; if (packet_count !== 9'd0) begin n_fail++; $display("FAIL reset.packet_count got %0d want 0", packet_count); end
    n_checks++; if (good_packet_count !== 9'd0) begin n_fail++; $display("FAIL reset.good_count got %0d want 0", good_packet_count); end
    n_checks++; if (missed_count !== 9'd0) begin n_fail++; $display("FAIL reset.missed_count got %0d want 0", missed_count); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_good_frame;
    logic [11:0] p0;
    int unsigned c0, d0;
    p0 = rd_idx; c0 = ncap; d0 = ndone;
    push_frame(16'h0060, GMAGIC, 16'd5, 16'd4, 16'h00A1);
    run_frame(1'b0, "good");
    n_checks++; if (ncap - c0 != 4) begin n_fail++; $display("FAIL good.words got %0d want 4", ncap - c0); end
    for (int unsigned i = 0; i < 4; i++) begin
      n_checks++; if (cap_data[c0 + i] !== 16'h00A1 + 16'(i)) begin n_fail++; $display("FAIL good.data[%0d] got %h want %h", i, cap_data[c0 + i], 16'h00A1 + 16'(i)); end
    end
    for (int unsigned i = 1; i < 4; i++) begin
      n_checks++; if (cap_cyc[c0 + i] != cap_cyc[c0 + i - 1] + 1) begin n_fail++; $display("FAIL good.consecutive[%0d] got cycle %0d want %0d", i, cap_cyc[c0 + i], cap_cyc[c0 + i - 1] + 1); end
    end
    n_checks++; if (rd_idx - p0 !== 12'd49) begin n_fail++; $display("FAIL good.pops_incl_len got %0d want 49", rd_idx - p0); end
    n_checks++; if (ndone - d0 != 1) begin n_fail++; $display("FAIL good.pkt_done_pulses got %0d want 1", ndone - d0); end
    n_checks++; if (packet_count !== 9'd1) begin n_fail++; $display("FAIL good.packet_count got %0d want 1", packet_count); end
    n_checks++; if (good_packet_count !== 9'd1) begin n_fail++; $display("FAIL good.good_count got %0d want 1", good_packet_count); end
    n_checks++; if (missed_count !== 9'd0) begin n_fail++; $display("FAIL good.missed_count got %0d want 0", missed_count); end
  endtask

  task automatic test_seq_gap;
    push_frame(16'h0060, GMAGIC, 16'd9, 16'd4, 16'h00B1);
    run_frame(1'b0, "seqgap");
    n_checks++; if (missed_count !== 9'd3) begin n_fail++; $display("FAIL seqgap.missed_count got %0d want 3", missed_count); end
    n_checks++; if (good_packet_count !== 9'd2) begin n_fail++; $display("FAIL seqgap.good_count got %0d want 2", good_packet_count); end
    n_checks++; if (packet_count !== 9'd2) begin n_fail++; $display("FAIL seqgap.packet_count got %0d want 2", packet_count); end
  endtask

  task automatic test_bad_magic;
    logic [11:0] p0;
    int unsigned c0;
    p0 = rd_idx; c0 = ncap;
    push_frame(16'h0060, 16'h1234, 16'd10, 16'd4, 16'h00C1);
    run_frame(1'b0, "badmagic");
    n_checks++; if (ncap != c0) begin n_fail++; $display("FAIL badmagic.words got %0d want 0", ncap - c0); end
    n_checks++; if (rd_idx - p0 !== 12'd49) begin n_fail++; $display("FAIL badmagic.pops_incl_len got %0d want 49", rd_idx - p0); end
    n_checks++; if (packet_count !== 9'd3) begin n_fail++; $display("FAIL badmagic.packet_count got %0d want 3", packet_count); end
    n_checks++; if (good_packet_count !== 9'd2) begin n_fail++; $display("FAIL badmagic.good_count got %0d want 2", good_packet_count); end
    c0 = ncap;
    push_frame(16'h0060, GMAGIC, 16'd10, 16'd2, 16'h00D1);
    run_frame(1'b0, "aftermagic");
    n_checks++; if (ncap - c0 != 2) begin n_fail++; $display("FAIL aftermagic.words got %0d want 2", ncap - c0); end
    n_checks++; if (cap_data[c0 + 1] !== 16'h00D2) begin n_fail++; $display("FAIL aftermagic.data1 got %h want 00d2", cap_data[c0 + 1]); end
    n_checks++; if (good_packet_count !== 9'd3) begin n_fail++; $display("FAIL aftermagic.good_count got %0d want 3", good_packet_count); end
    n_checks++; if (missed_count !== 9'd3) begin n_fail++; $display("FAIL aftermagic.missed_count got %0d want 3", missed_count); end
  endtask

  task automatic test_n_too_big;
    logic [11:0] p0;
    int unsigned c0;
    p0 = rd_idx; c0 = ncap;
    push_frame(16'h0060, GMAGIC, 16'd11, 16'd40, 16'h00E1);
    run_frame(1'b0, "nbig");
    n_checks++; if (ncap != c0) begin n_fail++; $display("FAIL nbig.words got %0d want 0", ncap - c0); end
    n_checks++; if (rd_idx - p0 !== 12'd49) begin n_fail++; $display("FAIL nbig.pops_incl_len got %0d want 49", rd_idx - p0); end
    n_checks++; if (packet_count !== 9'd5) begin n_fail++; $display("FAIL nbig.packet_count got %0d want 5", packet_count); end
    n_checks++; if (good_packet_count !== 9'd3) begin n_fail++; $display("FAIL nbig.good_count got %0d want 3", good_packet_count); end
  endtask

  // W=12 is the smallest legal frame; N=0 is good but forwards nothing.
  task automatic test_zero_payload;
    logic [11:0] p0;
    int unsigned c0;
    p0 = rd_idx; c0 = ncap;
    push_frame(16'h0018, GMAGIC, 16'd11, 16'd0, 16'h0000);
    run_frame(1'b0, "zeropay");
    n_checks++; if (ncap != c0) begin n_fail++; $display("FAIL zeropay.words got %0d want 0", ncap - c0); end
    n_checks++; if (rd_idx - p0 !== 12'd13) begin n_fail++; $display("FAIL zeropay.pops_incl_len got %0d want 13", rd_idx - p0); end
    n_checks++; if (good_packet_count !== 9'd4) begin n_fail++; $display("FAIL zeropay.good_count got %0d want 4", good_packet_count); end
    n_checks++; if (missed_count !== 9'd3) begin n_fail++; $display("FAIL zeropay.missed_count got %0d want 3", missed_count); end
  endtask

  task automatic test_backpressure;
    int unsigned c0, d0;
    c0 = ncap; d0 = ndone;
    push_frame(16'h0040, GMAGIC, 16'd12, 16'd20, 16'h5000);
    run_frame(1'b1, "backpr");
    n_checks++; if (ncap - c0 != 20) begin n_fail++; $display("FAIL backpr.words got %0d want 20", ncap - c0); end
    for (int unsigned i = 0; i < 20; i++) begin
      n_checks++; if (cap_data[c0 + i] !== 16'h5000 + 16'(i)) begin n_fail++; $display("FAIL backpr.data[%0d] got %h want %h", i, cap_data[c0 + i], 16'h5000 + 16'(i)); end
    end
    n_checks++; if (ndone - d0 != 1) begin n_fail++; $display("FAIL backpr.pkt_done_pulses got %0d want 1", ndone - d0); end
    n_checks++; if (good_packet_count !== 9'd5) begin n_fail++; $display("FAIL backpr.good_count got %0d want 5", good_packet_count); end
    n_checks++; if (rd_idx !== wr_idx) begin n_fail++; $display("FAIL backpr.fifo_left got %0d want 0", wr_idx - rd_idx); end
  endtask

  task automatic test_runt;
    logic [11:0] p0;
    int unsigned c0;
    p0 = rd_idx; c0 = ncap;
    push_frame(16'h0010, GMAGIC, 16'd13, 16'd1, 16'h0F00);
    run_frame(1'b0, "runt");
    n_checks++; if (ncap != c0) begin n_fail++; $display("FAIL runt.words got %0d want 0", ncap - c0); end
    n_checks++; if (rd_idx - p0 !== 12'd9) begin n_fail++; $display("FAIL runt.pops_incl_len got %0d want 9", rd_idx - p0); end
    n_checks++; if (packet_count !== 9'd8) begin n_fail++; $display("FAIL runt.packet_count got %0d want 8", packet_count); end
    n_checks++; if (good_packet_count !== 9'd5) begin n_fail++; $display("FAIL runt.good_count got %0d want 5", good_packet_count); end
  endtask

  task automatic test_reset_mid_data;
    int unsigned k;
    int unsigned c0;
    out_ready = 1'b0;
    push_frame(16'h0040, GMAGIC, 16'd20, 16'd20, 16'h7000);
    k = 0;
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst.reach_data got out_valid=%b want 1", out_valid); end
    reset_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst.out_valid got %b want 0", out_valid); end
    n_checks++; if (rx_fifo_rd_req !== 1'b0) begin n_fail++; $display("FAIL midrst.rd_req got %b want 0", rx_fifo_rd_req); end
    n_checks++; if (packet_count !== 9'd0) begin n_fail++; $display("FAIL midrst.packet_count got %0d want 0", packet_count); end
    n_checks++; if (good_packet_count !== 9'd0) begin n_fail++; $display("FAIL midrst.good_count got %0d want 0", good_packet_count); end
    n_checks++; if (missed_count !== 9'd0) begin n_fail++; $display("FAIL midrst.missed_count got %0d want 0", missed_count); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    c0 = ncap;
    push_frame(16'h0020, GMAGIC, 16'd3, 16'd2, 16'h0031);
    run_frame(1'b0, "postrst");
    n_checks++; if (ncap - c0 != 2) begin n_fail++; $display("FAIL postrst.words got %0d want 2", ncap - c0); end
    n_checks++; if (cap_data[c0] !== 16'h0031) begin n_fail++; $display("FAIL postrst.data0 got %h want 0031", cap_data[c0]); end
    n_checks++; if (packet_count !== 9'd1) begin n_fail++; $display("FAIL postrst.packet_count got %0d want 1", packet_count); end
    n_checks++; if (good_packet_count !== 9'd1) begin n_fail++; $display("FAIL postrst.good_count got %0d want 1", good_packet_count); end
    n_checks++; if (missed_count !== 9'd0) begin n_fail++; $display("FAIL postrst.missed_count got %0d want 0", missed_count); end
  endtask

  initial begin
    reset_n   = 1'b0;
    out_ready = 1'b1;
    gap       = 1'b0;
    flush     = 1'b0;
    repeat (3) @(negedge clk);
    test_reset;
    test_good_frame;
    test_seq_gap;
    test_bad_magic;
    test_n_too_big;
    test_zero_payload;
    test_backpressure;
    test_runt;
    test_reset_mid_data;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rtdf_packet_parser.md
# rtdf_packet_parser

Single-clock Ethernet frame parser for the real-time data feed. It sits between the DM9000A controller's RX FIFO and the sample-word buffer that feeds the 3-bit sample unpacker. It validates each received frame's header, strips the Ethernet, application and CRC overhead, and forwards only payload sample words through a valid/ready handshake. It also keeps the packet, good-packet and missed-packet debug counters.

## Interface
- ETHERTYPE, 16'h88B5, required Ethernet type word.
- MAGIC, 16'h4750, required first application word ("GP").
- MAX_WORDS, 16'd736, largest legal payload word count N.
- clk  input  1  single clock for all logic.
- reset_n  input  1  asynchronous, active-low reset.
- rx_fifo_empty  input  1  RX FIFO empty flag (show-ahead FIFO: data is valid whenever not empty).
- rx_fifo_rd_data  input  16  RX FIFO head word.
- rx_fifo_rd_req  output  1  pops the head word; combinational.
- out_ready  input  1  downstream buffer can accept a word.
- out_valid  output  1  out_data is a payload sample word; combinational.
- out_data  output  16  payload word, passed through unmodified (no byte swap).
- pkt_done  output  1  one-cycle pulse on the last pop of each frame; registered.
- packet_count  output  9  frames started, mod 512.
- good_packet_count  output  9  frames passing all checks, mod 512.
- missed_count  output  9  sequence numbers skipped, mod 512.

## Operation
- Frame word stream: L (byte length including 4-byte CRC), then 3 destination-MAC words, 3 source-MAC words, the ethertype word, MAGIC, SEQ, N, then N payload words, then padding and CRC.
- Total frame words: W = (L+1)>>1, computed in 16-bit arithmetic. An 11-bit word counter `cnt` counts pops since L.
- A word is accepted when rx_fifo_rd_req=1 and rx_fifo_empty=0.
- Outside DATA: rx_fifo_rd_req = !rx_fifo_empty.
- In DATA: out_valid = !rx_fifo_empty, out_data = rx_fifo_rd_data, and rx_fifo_rd_req = out_valid && out_ready.
- States:
  - LEN: accept L, latch W, packet_count+1. If W<12 → DRAIN; otherwise → MAC.
  - MAC: accept 6 words, discarded → TYPE.
  - TYPE: word ≠ ETHERTYPE → DRAIN; otherwise → MAGIC.
  - MAGIC: word ≠ MAGIC → DRAIN; otherwise → SEQ.
  - SEQ: latch the word as seq → COUNT.
  - COUNT: latch N.
    - Bad if N>MAX_WORDS or W<12+N (17-bit compare) → DRAIN, no counter update.
    - Good: good_packet_count+1 and sequence check (below).
    - Then: if N=0 → DRAIN, else → DATA.
  - DATA: forward N words; after the Nth accepted word → DRAIN.
  - DRAIN: pop until cnt reaches W.
    - The final pop asserts pkt_done the next cycle and returns to LEN.
    - If the frame ends exactly at a state boundary, go straight to LEN with pkt_done.
- Sequence check:
  - First good frame after reset only sets expected = seq+1.
  - Later good frames: missed_count += (seq − expected)[8:0]; then expected = seq+1 (16-bit wrap).
  - Duplicate or reordered frames therefore add large modular values; this is accepted debug behaviour.
- Counters wrap silently at 512.

## Timing
- Reset (async assert, sync release): state=LEN, all counters 0, pkt_done=0, seq-seen flag clear.
- rx_fifo_rd_req and out_valid are 0 during reset because their state terms are gated.
- Payload path latency: zero cycles, combinational pass-through.
- Throughput: one word per cycle when the FIFO is non-empty and out_ready=1.
- A stalled FIFO (empty) or stalled sink (out_ready=0) holds state and cnt. out_valid may drop mid-packet; the sink must not assume bursts.
- Counter updates land the cycle after the accepting edge. Simultaneous increments of different counters are independent.
- Reset asserted mid-frame: the remainder of that frame in the FIFO is misparsed. The owner of the upstream FIFO flushes it on the same reset.

## Test plan
- Good frame: L=0x0060 (W=48), correct type and magic, SEQ=5, N=4 with words A1..A4, out_ready=1.
  → out_data shows A1..A4 in 4 consecutive cycles; 48 pops total; pkt_done pulses once; packet_count=1, good_packet_count=1, missed_count=0.
- Two good frames with SEQ=5 then SEQ=9 → missed_count=3; good_packet_count=2.
- Bad magic 0x1234, L=0x0060 → out_valid never asserts; 48 pops; packet_count+1, good_packet_count unchanged; the next good frame parses correctly.
- N=40 with L=0x0060 (needs W≥52) → dropped and drained; no output words.
- Backpressure: toggle out_ready every cycle and insert random FIFO-empty gaps during DATA → payload order and count intact; no word lost or duplicated.
- Runt L=0x0010 (W=8) → 8 pops, DRAIN, no output; assert reset_n low mid-DATA → out_valid=0 immediately and all counters read 0.
